// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up on the final edge.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] hi_lo_write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   addend_divisor;
  logic [WIDTH-1:0]   dividend_raw;
  logic               is_div, negate_main, negate_rem, div_zero;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  assign busy = (state != IDLE);

  // Op[0]=0 selects the signed variants; magnitudes feed the unsigned core.
  assign a_neg = ~op[0] & operand_a[WIDTH-1];
  assign b_neg = ~op[0] & operand_b[WIDTH-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend/quotient bits}.
  assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc[0] ? addend_divisor : {WIDTH{1'b0}})};
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, addend_divisor};

  assign fix_prod = negate_main ? -acc : acc;
  assign fix_quo  = negate_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign fix_rem  = negate_rem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = op[1] ? DIV : MUL;
      MUL, DIV: if (count == CW'(1)) next_state = FIX;
      FIX:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count          <= '0;
      acc            <= '0;
      addend_divisor <= '0;
      dividend_raw   <= '0;
      is_div         <= 1'b0;
      negate_main    <= 1'b0;
      negate_rem     <= 1'b0;
      div_zero       <= 1'b0;
      done           <= 1'b0;
      hi             <= '0;
      lo             <= '0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (hi_write) hi <= hi_lo_write_data;
          if (lo_write) lo <= hi_lo_write_data;
          if (start) begin
            count        <= CW'(WIDTH);
            is_div       <= op[1];
            negate_main  <= a_neg ^ b_neg;
            negate_rem   <= a_neg;
            div_zero     <= (operand_b == '0);
            dividend_raw <= operand_a;
            if (op[1]) begin
              acc            <= {{WIDTH{1'b0}}, a_mag};
              addend_divisor <= b_mag;
            end else begin
              acc            <= {{WIDTH{1'b0}}, b_mag};
              addend_divisor <= a_mag;
            end
          end
        end
        MUL: begin
          acc   <= {sum, acc[WIDTH-1:1]};
          count <= count - CW'(1);
        end
        DIV: begin
          // Borrow out of the trial subtraction means the divisor did not fit.
          if (trial[WIDTH]) acc <= {acc[2*WIDTH-2:0], 1'b0};
          else              acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          count <= count - CW'(1);
        end
        FIX: begin
          if (is_div) begin
            if (div_zero) begin
              lo <= {WIDTH{1'b1}};
              hi <= dividend_raw;
            end else begin
              lo <= fix_quo;
              hi <= fix_rem;
            end
          end else begin
            hi <= fix_prod[2*WIDTH-1:WIDTH];
            lo <= fix_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO from an arithmetic
// reference model, and an independent monitor pops and compares on every Done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_write, lo_write;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, hi_lo_write_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          busy_cycles = 0;
  logic [31:0] mdl_hi, mdl_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_write(hi_write), .lo_write(lo_write), .hi_lo_write_data(hi_lo_write_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural result {hi, lo} computed with plain signed/unsigned arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sbv; return p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cycles = 0;
    end else begin
      if (busy) busy_cycles++;
      if (done) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_output("hi", hi, e.hi);
          check_output("lo", lo, e.lo);
          check_output("done_latency", cyc, e.due);
          check_output("busy_cycles", busy_cycles, 33);
          check_output("busy_in_done", {31'b0, busy}, 32'd0);
        end
        busy_cycles = 0;
      end
    end
  end

  // Called just after a negedge; returns just after the following negedge.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    int g = 0;
    while (busy && g < 200) begin @(negedge clk); g++; end
    if (busy) check_output("idle_timeout", 32'd1, 32'd0);
    r = ref_model(o, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.due = cyc + 34;
    sb.push_back(e);
    mdl_hi = e.hi;
    mdl_lo = e.lo;
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    do begin @(negedge clk); g++; end while (!done && g < 100);
    if (!done) check_output("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    hi_write = hw; lo_write = lw; hi_lo_write_data = d;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    if (hw) mdl_hi = d;
    if (lw) mdl_lo = d;
    check_output("mt_hi", hi, mdl_hi);
    check_output("mt_lo", lo, mdl_lo);
  endtask

  initial begin
    int seen;
    logic [1:0]  o;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    op = 2'b00; operand_a = '0; operand_b = '0; hi_lo_write_data = '0;
    repeat (2) @(negedge clk);
    check_output("reset_busy", {31'b0, busy}, 32'd0);
    check_output("reset_done", {31'b0, done}, 32'd0);
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    reset = 1'b0;
    mdl_hi = '0; mdl_lo = '0;

    apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    apply_stimulus(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done();
    apply_stimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    apply_stimulus(2'b11, 32'd100, 32'd0);
    wait_done();
    apply_stimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();

    // Start and MTLO during an operation must be ignored.
    apply_stimulus(2'b11, 32'd50, 32'd7);
    repeat (3) @(negedge clk);
    op = 2'b01; operand_a = 32'd2; operand_b = 32'd2; start = 1'b1;
    lo_write = 1'b1; hi_lo_write_data = 32'h0000_AAAA;
    @(negedge clk);
    start = 1'b0; lo_write = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset in mid-flight aborts without committing a result.
    apply_stimulus(2'b01, 32'd3, 32'd4);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_done", {31'b0, done}, 32'd0);
    check_output("abort_hi", hi, 32'd0);
    check_output("abort_lo", lo, 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    check_output("no_done_after_reset", seen, 0);
    apply_stimulus(2'b01, 32'd3, 32'd4);
    wait_done();
    @(negedge clk);

    write_hilo(1'b1, 1'b0, 32'h1234_5678);
    write_hilo(1'b1, 1'b1, 32'h0000_0055);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        2: a = 32'h8000_0000;
        3: b = 32'($signed(-$urandom_range(1, 9)));
        default: ;
      endcase
      apply_stimulus(o, a, b);
      wait_done();
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
      end
    end

    seen = 0;
    while (sb.size() != 0 && seen < 100) begin @(negedge clk); seen++; end
    check_output("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the register bank and consumes its two read-data outputs (rs, rt) as operands.
- Executes MULT, MULTU, DIV and DIVU over 33 cycles, and holds the results in the architectural HI/LO registers.
- Also services MTHI/MTLO writes. HI/LO feed MFHI/MFLO back toward the register-bank write path.
- Control sees a Start/Busy/Done handshake and stalls the PC while Busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; sampled only when Busy=0.
- Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  input  WIDTH  rs value; multiplicand or dividend.
- OperandB  input  WIDTH  rt value; multiplier or divisor.
- HiWrite  input  1  MTHI strobe.
- LoWrite  input  1  MTLO strobe.
- HiLoWriteData  input  WIDTH  data for MTHI/MTLO.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when a result has been committed.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high):
  - State=IDLE; Busy=0, Done=0, Hi=0, Lo=0; all internal registers cleared.
  - Reset dominates every other input and aborts any operation in flight; no result is committed.
- States:
  - IDLE, MUL, DIV, FIX.
  - Done is a registered output, asserted on the FIX→IDLE transition.
- IDLE:
  - Start=1 at edge E0: OperandA, OperandB and Op are latched, the counter is loaded with WIDTH, Busy=1, and the state moves to MUL or DIV.
  - For the signed ops, operand magnitudes and a result-sign flag are latched.
- MUL:
  - Shift-add, one multiplier bit per cycle, over edges E1..E32.
  - 64-bit accumulator; unsigned arithmetic on magnitudes.
- DIV:
  - Restoring division, one quotient bit per cycle, over edges E1..E32.
  - Unsigned arithmetic on magnitudes.
- FIX (edge E33): sign correction, then Hi/Lo load.
  - Signed multiply: the 64-bit product is negated if the operand signs differ.
  - Signed divide: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Multiply: Hi = product[63:32], Lo = product[31:0].
  - Divide: Lo = quotient, Hi = remainder.
  - At the same edge: Busy→0, Done→1, state→IDLE.
- Latency and handshake:
  - Results are visible on Hi/Lo, with Done=1, during the cycle after E33.
  - Done lasts exactly one cycle.
  - Start is accepted in the Done cycle (Busy=0), giving back-to-back throughput of one operation per 34 cycles.
  - Start while Busy=1 is ignored; operands are not resampled.
- Divide by zero (signed and unsigned):
  - Lo = all ones, Hi = OperandA as latched.
  - Same 33-cycle latency; no exception is raised.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- MTHI/MTLO:
  - HiWrite/LoWrite update Hi/Lo at the next edge only when Busy=0; they are ignored while Busy=1.
  - If coincident with an accepted Start, the write happens now and is overwritten at E33.
  - HiWrite and LoWrite together write both registers.
- Hi and Lo are unchanged outside of reset, the FIX edge and accepted MTHI/MTLO writes.

Test Plan:
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high for 33 cycles; then Done pulse, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT, A=0xFFFFFFFD (-3), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Back-to-back Start in the Done cycle with DIV, A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU, A=100, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000064. DIV, A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start DIVU 50/7. At cycle 5, pulse Start with MULTU 2*2 and LoWrite with data 0xAAAA -> both ignored; final Lo=7, Hi=1.
- Pulse Reset at cycle 10 of MULTU 3*4 -> next cycle Busy=0, Done=0, Hi=Lo=0, and no Done pulse follows. A new MULTU 3*4 then gives Lo=12, Hi=0.
- Idle: HiWrite with data 0x12345678 -> Hi=0x12345678 next cycle, Lo unchanged. HiWrite and LoWrite with data 0x55 -> Hi=Lo=0x55.
